// File: rtl/ra_cfg_loader_sdr.sv
// Serial-to-parallel configuration loader for ra_cfg_sdr: decodes framed
// bit-serial write/read commands and drives single-cycle cfg writes or serial readback.
module ra_cfg_loader_sdr #(
  parameter int CFG_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ser_sel,
  input  logic                 ser_vld,
  input  logic                 ser_din,
  output logic                 ser_dout,
  input  logic [0:CFG_WIDTH-1] cfg,
  output logic                 cfg_wr,
  output logic [0:CFG_WIDTH-1] cfg_dat,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WDATA = 2'd1;
  localparam logic [1:0] RDATA = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam int CNT_W = $clog2(CFG_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]           state;
  logic [CNT_W-1:0]     cnt;
  logic [0:CFG_WIDTH-1] shift_q;
  logic [0:CFG_WIDTH-1] shadow;

  // Handshake: a beat is any rising edge with ser_sel=1 and ser_vld=1; there is
  // no back-pressure. ser_vld=0 cycles are gaps and leave all state untouched,
  // while ser_sel=0 outside IDLE/HOLD aborts the frame.
  logic beat;
  assign beat      = ser_sel & ser_vld;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      shift_q    <= '0;
      shadow     <= '0;
      cfg_wr     <= 1'b0;
      cfg_dat    <= '0;
      ser_dout   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cfg_wr     <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (beat) begin
            cnt <= '0;
            if (ser_din) begin
              state <= WDATA;
            end else begin
              // Snapshot cfg now so later cfg changes cannot corrupt the readback.
              state    <= RDATA;
              shadow   <= cfg;
              ser_dout <= cfg[0];
            end
          end
        end
        WDATA: begin
          if (!ser_sel) begin
            state     <= IDLE;
            cnt       <= '0;
            frame_err <= 1'b1;
          end else if (ser_vld) begin
            shift_q <= {shift_q[1:CFG_WIDTH-1], ser_din};
            if (cnt == CNT_LAST) begin
              cnt        <= '0;
              cfg_dat    <= {shift_q[1:CFG_WIDTH-1], ser_din};
              cfg_wr     <= 1'b1;
              frame_done <= 1'b1;
              state      <= HOLD;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        RDATA: begin
          if (!ser_sel) begin
            state     <= IDLE;
            cnt       <= '0;
            frame_err <= 1'b1;
            ser_dout  <= 1'b0;
          end else if (ser_vld) begin
            shadow <= {shadow[1:CFG_WIDTH-1], 1'b0};
            if (cnt == CNT_LAST) begin
              cnt        <= '0;
              frame_done <= 1'b1;
              ser_dout   <= 1'b0;
              state      <= HOLD;
            end else begin
              cnt      <= cnt + CNT_ONE;
              ser_dout <= shadow[1];
            end
          end
        end
        HOLD: begin
          if (!ser_sel) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ra_cfg_loader_sdr.sv
// Directed bench for ra_cfg_loader_sdr: write, read, gapped, abort, overrun and
// mid-frame reset scenarios with hand-computed expectations.
module tb_ra_cfg_loader_sdr;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic        clk;
  logic        reset;
  logic        ser_sel;
  logic        ser_vld;
  logic        ser_din;
  logic        ser_dout;
  logic [15:0] cfg;
  logic        cfg_wr;
  logic [15:0] cfg_dat;
  logic        frame_done;
  logic        frame_err;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  ra_cfg_loader_sdr #(.CFG_WIDTH(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .ser_sel    (ser_sel),
    .ser_vld    (ser_vld),
    .ser_din    (ser_din),
    .ser_dout   (ser_dout),
    .cfg        (cfg),
    .cfg_wr     (cfg_wr),
    .cfg_dat    (cfg_dat),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: apply inputs, then sample 1 time unit after the next rising edge
  task automatic drive(input logic s, input logic v, input logic d);
    ser_sel = s;
    ser_vld = v;
    ser_din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; ser_sel = 1'b0; ser_vld = 1'b0; ser_din = 1'b0; cfg = 16'h0;
    #3;
    n_cmp++;
    if ({cfg_wr, frame_done, frame_err, ser_dout} !== 4'b0000) begin
      n_err++; $display("FAIL reset_strobes got %b want 0000", {cfg_wr, frame_done, frame_err, ser_dout});
    end
    n_cmp++;
    if (cfg_dat !== 16'h0000) begin
      n_err++; $display("FAIL reset_cfg_dat got %h want 0000", cfg_dat);
    end
    n_cmp++;
    if (dbg_state !== S_IDLE) begin
      n_err++; $display("FAIL reset_state got %0d want %0d", dbg_state, S_IDLE);
    end
    #10 reset = 1'b1;
    drive(0, 0, 0);
    drive(0, 0, 0);
  endtask

  task automatic test_write();
    logic [15:0] w;
    w = 16'hA5C3;
    drive(1, 1, 1);
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, w[15-i]);
      if (i < 15) begin
        n_cmp++;
        if (cfg_wr !== 1'b0 || frame_done !== 1'b0 || ser_dout !== 1'b0) begin
          n_err++; $display("FAIL write_early beat %0d wr %b done %b dout %b want 0", i, cfg_wr, frame_done, ser_dout);
        end
      end
    end
    n_cmp++;
    if (cfg_wr !== 1'b1 || frame_done !== 1'b1 || frame_err !== 1'b0) begin
      n_err++; $display("FAIL write_pulse wr %b done %b err %b want 1 1 0", cfg_wr, frame_done, frame_err);
    end
    n_cmp++;
    if (cfg_dat !== w) begin
      n_err++; $display("FAIL write_data got %h want %h", cfg_dat, w);
    end
    drive(1, 0, 0);
    n_cmp++;
    if (cfg_wr !== 1'b0 || frame_done !== 1'b0 || cfg_dat !== w) begin
      n_err++; $display("FAIL write_after wr %b done %b dat %h want 0 0 %h", cfg_wr, frame_done, cfg_dat, w);
    end
    n_cmp++;
    if (dbg_state !== S_HOLD) begin
      n_err++; $display("FAIL write_hold state %0d want %0d", dbg_state, S_HOLD);
    end
    drive(0, 0, 0);
    n_cmp++;
    if (dbg_state !== S_IDLE) begin
      n_err++; $display("FAIL write_idle state %0d want %0d", dbg_state, S_IDLE);
    end
  endtask

  task automatic test_read();
    logic [15:0] exp_bits;
    exp_bits = 16'b0001_0010_0011_0100;
    cfg = 16'h1234;
    drive(1, 1, 0);
    cfg = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (ser_dout !== exp_bits[15-i]) begin
        n_err++; $display("FAIL read_bit %0d got %b want %b", i, ser_dout, exp_bits[15-i]);
      end
      drive(1, 1, 0);
      n_cmp++;
      if (cfg_wr !== 1'b0) begin
        n_err++; $display("FAIL read_no_wr beat %0d got %b want 0", i, cfg_wr);
      end
    end
    n_cmp++;
    if (frame_done !== 1'b1 || ser_dout !== 1'b0 || cfg_dat !== 16'hA5C3) begin
      n_err++; $display("FAIL read_end done %b dout %b dat %h want 1 0 a5c3", frame_done, ser_dout, cfg_dat);
    end
    drive(0, 0, 0);
    n_cmp++;
    if (frame_done !== 1'b0 || frame_err !== 1'b0) begin
      n_err++; $display("FAIL read_release done %b err %b want 0 0", frame_done, frame_err);
    end
  endtask

  task automatic test_abort();
    logic [15:0] w;
    w = 16'h0F0F;
    drive(1, 1, 1);
    for (int i = 0; i < 8; i++) drive(1, 1, w[15-i]);
    drive(0, 0, 0);
    n_cmp++;
    if (frame_err !== 1'b1 || cfg_wr !== 1'b0 || frame_done !== 1'b0) begin
      n_err++; $display("FAIL abort_pulse err %b wr %b done %b want 1 0 0", frame_err, cfg_wr, frame_done);
    end
    n_cmp++;
    if (cfg_dat !== 16'hA5C3) begin
      n_err++; $display("FAIL abort_hold_dat got %h want a5c3", cfg_dat);
    end
    drive(0, 0, 0);
    n_cmp++;
    if (frame_err !== 1'b0 || dbg_state !== S_IDLE) begin
      n_err++; $display("FAIL abort_after err %b state %0d want 0 0", frame_err, dbg_state);
    end
  endtask

  task automatic test_gapped();
    logic [15:0] w;
    int wr_seen;
    w = 16'h8001;
    wr_seen = 0;
    drive(1, 1, 1);
    for (int i = 0; i < 16; i++) begin
      int gap;
      gap = $urandom_range(1, 3);
      for (int g = 0; g < gap; g++) begin
        drive(1, 0, ~w[15-i]);
        if (cfg_wr === 1'b1) wr_seen++;
      end
      drive(1, 1, w[15-i]);
      if (i < 15 && cfg_wr === 1'b1) wr_seen++;
    end
    n_cmp++;
    if (cfg_wr !== 1'b1 || frame_done !== 1'b1 || cfg_dat !== w) begin
      n_err++; $display("FAIL gapped_end wr %b done %b dat %h want 1 1 %h", cfg_wr, frame_done, cfg_dat, w);
    end
    n_cmp++;
    if (wr_seen !== 0) begin
      n_err++; $display("FAIL gapped_early_wr got %0d want 0", wr_seen);
    end
    drive(1, 0, 0);
    n_cmp++;
    if (cfg_wr !== 1'b0 || cfg_dat !== w) begin
      n_err++; $display("FAIL gapped_after wr %b dat %h want 0 %h", cfg_wr, cfg_dat, w);
    end
    drive(0, 0, 0);
  endtask

  task automatic test_overrun();
    logic [15:0] w;
    int wr_cnt;
    w = 16'h3C5A;
    wr_cnt = 0;
    drive(1, 1, 1);
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, w[15-i]);
      if (cfg_wr === 1'b1) wr_cnt++;
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, i[0]);
      if (cfg_wr === 1'b1) wr_cnt++;
    end
    drive(0, 0, 0);
    if (cfg_wr === 1'b1) wr_cnt++;
    n_cmp++;
    if (wr_cnt !== 1) begin
      n_err++; $display("FAIL overrun_wr_count got %0d want 1", wr_cnt);
    end
    n_cmp++;
    if (frame_err !== 1'b0 || cfg_dat !== w) begin
      n_err++; $display("FAIL overrun_end err %b dat %h want 0 %h", frame_err, cfg_dat, w);
    end
    drive(0, 0, 0);
  endtask

  task automatic test_reset_mid();
    logic [15:0] w;
    drive(1, 1, 1);
    for (int i = 0; i < 9; i++) drive(1, 1, 1'b1);
    ser_sel = 1'b1; ser_vld = 1'b1; ser_din = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({cfg_wr, frame_done, frame_err, ser_dout} !== 4'b0000 || cfg_dat !== 16'h0000) begin
      n_err++; $display("FAIL midreset_outputs strobes %b dat %h want 0000 0000", {cfg_wr, frame_done, frame_err, ser_dout}, cfg_dat);
    end
    n_cmp++;
    if (dbg_state !== S_IDLE) begin
      n_err++; $display("FAIL midreset_state got %0d want %0d", dbg_state, S_IDLE);
    end
    ser_sel = 1'b0; ser_vld = 1'b0;
    #10 reset = 1'b1;
    drive(0, 0, 0);
    w = 16'h00FF;
    drive(1, 1, 1);
    for (int i = 0; i < 16; i++) drive(1, 1, w[15-i]);
    n_cmp++;
    if (cfg_wr !== 1'b1 || frame_done !== 1'b1 || cfg_dat !== w) begin
      n_err++; $display("FAIL midreset_rewrite wr %b done %b dat %h want 1 1 %h", cfg_wr, frame_done, cfg_dat, w);
    end
    drive(0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_gapped();
    test_overrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ra_cfg_loader_sdr.md
Name: ra_cfg_loader_sdr

Overview:
- Serial-to-parallel configuration loader; the transmitting end of the cfg_wr/cfg_dat interface consumed by ra_cfg_sdr.
- Accepts framed bit-serial commands from a chip-level test port and issues single-cycle config writes to ra_cfg_sdr.
- Serially shifts out the current cfg value for readback.
- Sits beside ra_cfg_sdr/ra_lcb_sdr in the SDR test array, clocked by the array clk.

Parameters:
- CFG_WIDTH, 16, config word width; must equal `LCBSDR_CONFIGWIDTH.

Ports:
- clk        input   1          array clock; all state changes on rising edge.
- reset      input   1          asynchronous, active-low reset.
- ser_sel    input   1          frame select; high for the whole frame.
- ser_vld    input   1          bit-valid strobe; one serial beat per clk with ser_vld=1.
- ser_din    input   1          serial data in, sampled when ser_sel&ser_vld.
- ser_dout   output  1          serial readback data.
- cfg        input   CFG_WIDTH  current config from ra_cfg_sdr, [0:CFG_WIDTH-1].
- cfg_wr     output  1          one-cycle write strobe to ra_cfg_sdr.
- cfg_dat    output  CFG_WIDTH  write data to ra_cfg_sdr; held between writes.
- frame_done output  1          one-cycle pulse: frame completed successfully.
- frame_err  output  1          one-cycle pulse: frame aborted before completion.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, bit counter=0, shift and shadow registers=0.
  - cfg_wr=0, cfg_dat=0, ser_dout=0, frame_done=0, frame_err=0.
- Beat: a rising edge with ser_sel=1 and ser_vld=1. ser_vld=0 cycles are gaps; they change no state and can occur anywhere.
- Bit order: MSB-first; bit index 0 of the [0:CFG_WIDTH-1] vector is transferred first.
- IDLE:
  - The first beat is the command bit.
  - ser_din=1: go to WDATA, counter=0.
  - ser_din=0: go to RDATA, counter=0, shadow<=cfg, captured on that same edge.
- WDATA:
  - Each beat: shift register <= {shift[1:W-1], ser_din}, counter+1.
  - The beat with counter==CFG_WIDTH-1 completes the frame. On that edge: cfg_dat <= assembled word, cfg_wr<=1, frame_done<=1, go to HOLD.
  - cfg_wr and frame_done are high for exactly the one cycle after the last data beat.
- RDATA:
  - ser_dout = shadow[0], registered; valid from the cycle after the command beat.
  - Each beat consumes the presented bit: shadow shifts left, counter+1.
  - The beat with counter==CFG_WIDTH-1 ends the frame: frame_done<=1, go to HOLD, ser_dout<=0.
  - cfg changing during RDATA does not affect the shifted value.
  - No cfg_wr is issued in a read frame.
- HOLD:
  - Further beats are ignored; no write, no error.
  - ser_sel=0 returns to IDLE.
- Abort: ser_sel=0 while in WDATA or RDATA:
  - Go to IDLE and pulse frame_err for one cycle.
  - No cfg_wr; cfg_dat keeps its previous value; ser_dout<=0.
- ser_sel=0 in IDLE: no action. A new frame requires ser_sel to be low for at least one cycle after HOLD.
- ser_dout=0 in every state except RDATA.
- cfg_wr, frame_done and frame_err are never high simultaneously except cfg_wr with frame_done.
- Reset asserted mid-frame: immediate return to reset values; any partial write is discarded.
- Latency:
  - Write frame: CFG_WIDTH+1 beats; cfg_wr one cycle after the last beat.
  - Read frame: first data bit one cycle after the command beat.
- Counter width: clog2(CFG_WIDTH); no wrap, since the frame ends at CFG_WIDTH-1.

Test Plan:
- Write: ser_sel=1, 17 back-to-back beats (1, then 16'hA5C3 MSB-first) -> cfg_wr=1 and frame_done=1 for exactly one cycle after beat 17; cfg_dat=16'hA5C3, held afterwards; ra_cfg_sdr cfg reads 16'hA5C3.
- Read: cfg=16'h1234, command bit 0, then 16 beats; cfg changed to 16'hFFFF after the command beat -> ser_dout sequence = 0001_0010_0011_0100; frame_done pulses; cfg_wr stays 0.
- Gapped write: beats separated by 1-3 ser_vld=0 cycles, data 16'h8001 -> same result as back-to-back; cfg_wr only after the 17th beat.
- Abort: write frame, ser_sel dropped after 8 data bits -> frame_err one-cycle pulse; no cfg_wr; cfg_dat keeps its prior value 16'hA5C3; the next full frame succeeds.
- Overrun: 20 beats in one write frame -> one cfg_wr only; beats 18-20 ignored; no frame_err when ser_sel drops.
- Reset mid-frame: reset=0 during WDATA beat 10 -> all outputs 0 immediately; after release, a full write of 16'h00FF succeeds.
